// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch FSM encoding, IF/ID entry layout and
// architectural constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH_REQ   = 2'd0,
    FETCH_WAIT  = 2'd1,
    FETCH_HOLD  = 2'd2,
    FETCH_DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;
  localparam logic [31:0] DEF_RESET_PC    = 32'h0000_1000;
  localparam logic [31:0] DEF_TRAP_VECTOR = 32'h0000_2000;

  // One IF/ID slot: the PC, the instruction word and the misaligned-PC flag.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } if_entry_t;

  localparam if_entry_t NOP_ENTRY = '{pc: 32'd0, instr: NOP_INSTR, fault: 1'b0};

endpackage

// File: rtl/if_id_register.sv
// IF/ID output register plus a single-entry skid buffer. The skid catches a
// cache response that lands while decode is stalled so the cache never has
// to be back-pressured.
module if_id_register
  import cpu_pkg::*;
(
  input  logic      clk,
  input  logic      i_reset_n,
  input  logic      i_flush,
  input  logic      i_stall,
  input  logic      i_load,
  input  logic      i_skid_wr,
  input  logic      i_skid_rd,
  input  if_entry_t i_entry,
  output logic      o_valid,
  output if_entry_t o_entry
);

  logic      r_valid;
  if_entry_t r_entry;
  logic      r_skid_valid;
  if_entry_t r_skid;

  // Output slot and skid buffer; flush kills both, even under stall.
  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      r_valid      <= 1'b0;
      r_entry      <= NOP_ENTRY;
      r_skid_valid <= 1'b0;
      r_skid       <= NOP_ENTRY;
    end else if (i_flush) begin
      r_valid      <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      if (i_load) begin
        r_valid <= 1'b1;
        r_entry <= i_entry;
      end else if (i_skid_rd && r_skid_valid) begin
        r_valid      <= 1'b1;
        r_entry      <= r_skid;
        r_skid_valid <= 1'b0;
      end else if (!i_stall) begin
        // decode took the entry and nothing replaces it
        r_valid <= 1'b0;
      end
      if (i_skid_wr) begin
        r_skid_valid <= 1'b1;
        r_skid       <= i_entry;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_entry = r_entry;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, keeps at most one I-cache request in
// flight and feeds decode through the IF/ID register. Redirects and traps
// can land in any state; a response to a request issued before the redirect
// is swallowed in DRAIN.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
  parameter logic [31:0] TRAP_VECTOR = DEF_TRAP_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        trap,
  output logic        icache_req_valid,
  output logic [31:0] icache_req_addr,
  input  logic        icache_req_ready,
  input  logic        icache_resp_valid,
  input  logic [31:0] icache_resp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instruction,
  output logic        if_fault
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;

  logic        w_flush;
  logic [31:0] w_target;
  logic        w_aligned;
  logic        w_out_free;
  logic        w_load;
  logic        w_skid_wr;
  logic        w_skid_rd;
  if_entry_t   w_entry;
  if_entry_t   w_out_entry;

  // trap outranks a simultaneous redirect
  assign w_flush    = trap || redirect_valid;
  assign w_target   = trap ? TRAP_VECTOR : redirect_pc;
  assign w_aligned  = (r_pc[1:0] == 2'b00);
  assign w_out_free = !if_valid || !stall;

  // Request depends only on state, PC and redirect inputs, never on the response.
  assign icache_req_valid = (r_state == FETCH_REQ) && !w_flush && w_aligned;
  assign icache_req_addr  = r_pc;

  // Decide what enters the IF/ID register or the skid buffer this cycle.
  always_comb begin
    w_load    = 1'b0;
    w_skid_wr = 1'b0;
    w_skid_rd = 1'b0;
    w_entry   = '{pc: r_pc, instr: icache_resp_data, fault: 1'b0};
    if (!w_flush) begin
      case (r_state)
        FETCH_REQ: begin
          if (!w_aligned && w_out_free) begin
            w_load        = 1'b1;
            w_entry.instr = NOP_INSTR;
            w_entry.fault = 1'b1;
          end
        end
        FETCH_WAIT: begin
          if (icache_resp_valid) begin
            w_load    = w_out_free;
            w_skid_wr = !w_out_free;
          end
        end
        FETCH_HOLD:  w_skid_rd = !stall;
        default: ;
      endcase
    end
  end

  // Fetch FSM and PC; a misaligned PC parks in REQ until redirected.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= FETCH_REQ;
      r_pc    <= RESET_PC;
    end else if (w_flush) begin
      r_pc <= w_target;
      case (r_state)
        FETCH_WAIT,
        FETCH_DRAIN: r_state <= icache_resp_valid ? FETCH_REQ : FETCH_DRAIN;
        default:     r_state <= FETCH_REQ;
      endcase
    end else begin
      case (r_state)
        FETCH_REQ: begin
          if (icache_req_valid && icache_req_ready) r_state <= FETCH_WAIT;
        end
        FETCH_WAIT: begin
          if (icache_resp_valid) begin
            if (w_out_free) begin
              r_pc    <= r_pc + 32'd4;
              r_state <= FETCH_REQ;
            end else begin
              r_state <= FETCH_HOLD;
            end
          end
        end
        FETCH_HOLD: begin
          if (!stall) begin
            r_pc    <= r_pc + 32'd4;
            r_state <= FETCH_REQ;
          end
        end
        FETCH_DRAIN: begin
          if (icache_resp_valid) r_state <= FETCH_REQ;
        end
        default: r_state <= FETCH_REQ;
      endcase
    end
  end

  if_id_register u_if_id (
    .clk       (clk),
    .i_reset_n (reset),
    .i_flush   (w_flush),
    .i_stall   (stall),
    .i_load    (w_load),
    .i_skid_wr (w_skid_wr),
    .i_skid_rd (w_skid_rd),
    .i_entry   (w_entry),
    .o_valid   (if_valid),
    .o_entry   (w_out_entry)
  );

  assign if_pc          = w_out_entry.pc;
  assign if_instruction = w_out_entry.instr;
  assign if_fault       = w_out_entry.fault;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage feeding decode_stage.
- Owns the PC and issues one request at a time to the instruction cache, which may take several cycles.
- Presents {valid, pc, instruction, fault} in an IF/ID output register.
- Handles decode stalls, branch/jump redirects and trap/iret redirects, discarding stale cache responses.

Parameters:
- RESET_PC, 32'h0000_1000, PC loaded on reset.
- TRAP_VECTOR, 32'h0000_2000, PC loaded on trap.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- stall  in  1  downstream cannot accept; hold IF/ID register.
- redirect_valid  in  1  taken branch/jump/iret from later stage.
- redirect_pc  in  32  target for redirect_valid.
- trap  in  1  exception/panic; has priority over redirect_valid.
- icache_req_valid  out  1  request valid.
- icache_req_addr  out  32  word address (= pc).
- icache_req_ready  in  1  cache accepts request this cycle.
- icache_resp_valid  in  1  response valid, exactly one per accepted request, at least 1 cycle after acceptance.
- icache_resp_data  in  32  instruction word.
- if_valid  out  1  IF/ID register holds an instruction.
- if_pc  out  32  PC of held instruction.
- if_instruction  out  32  held instruction.
- if_fault  out  1  held entry is a misaligned-PC fault; instruction = 32'h0000_0013 (nop).

Behaviour:
- Reset (reset==0 at edge):
  - pc=RESET_PC, state=REQ.
  - if_valid=0, if_pc=0, if_instruction=32'h0000_0013, if_fault=0, skid buffer empty.
  - Any outstanding request is forgotten. The cache is reset by the same signal.
- States:
  - REQ: icache_req_valid = !trap && !redirect_valid && pc[1:0]==0. On accept, go to WAIT.
  - WAIT: waiting for the response.
  - HOLD: response captured in the skid buffer while stalled.
  - DRAIN: waiting for and discarding a stale response.
- "Output free" = !if_valid || !stall.
- REQ with pc[1:0]!=0 and no redirect:
  - No request is issued.
  - When the output is free, load if_valid=1, if_fault=1, if_pc=pc.
  - pc does not advance; stay in REQ until a trap/redirect.
- WAIT with resp_valid:
  - Output free: load if_valid=1, if_pc=pc, if_instruction=data, if_fault=0; pc+=4; go to REQ.
  - Otherwise: capture data in the skid buffer and go to HOLD.
- HOLD: when !stall, move the buffer to the output, pc+=4, go to REQ.
- Output drain: if stall==0, nothing new is loaded and the output is not being refilled, clear if_valid=0 the next cycle.
- Redirect/trap (any state):
  - New pc = trap ? TRAP_VECTOR : redirect_pc.
  - if_valid=0 next cycle, even under stall; the skid buffer is cleared.
  - From REQ or HOLD: go to REQ.
  - From WAIT with resp_valid in the same cycle: the response is dropped; go to REQ.
  - From WAIT without resp_valid: go to DRAIN.
  - From DRAIN: stay in DRAIN; pc is updated to the newest target.
- DRAIN with resp_valid: drop the data, go to REQ.
- Throughput:
  - One instruction per 2 cycles minimum (REQ→WAIT, 1-cycle hit).
  - Latency from request acceptance to if_valid = response latency + 1 edge.
- pc arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- No combinational path from icache_resp_* to icache_req_*.

Decomposition:
- Shared package cpu_pkg holds:
  - state encoding FETCH_REQ/WAIT/HOLD/DRAIN (2 bits);
  - NOP_INSTR = 32'h0000_0013;
  - RESET_PC and TRAP_VECTOR defaults.
- One natural sub-module: if_id_register, holding the output register and the 1-entry skid buffer with the stall/flush rules. The FSM and PC stay in fetch_stage.

Test Plan:
- Reset then hits: cache responds 1 cycle after each accept with data=addr^32'hA5A5_0000 → if_pc sequence 0x1000, 0x1004, 0x1008; if_valid pulses every 2nd cycle; request addresses match.
- Miss with stall: response at 0x1004 arrives after 5 cycles while stall=1 for 3 more cycles → HOLD state; no new request issued; instruction appears when stall drops; pc then 0x1008.
- Redirect during miss: redirect_pc=0x2400 asserted in WAIT, stale response arrives 3 cycles later → if_valid stays 0; next request address is 0x2400; stale data never reaches the output.
- Redirect and response in the same cycle in WAIT: response dropped; next request is to the redirect target; no DRAIN visit.
- Trap and redirect together (redirect_pc=0x3000) → next request address is 0x2000; if_valid=0 the following cycle even with stall=1.
- Misaligned redirect_pc=0x1002 → no request; if_valid=1, if_fault=1, if_pc=0x1002, if_instruction=0x13; a later redirect to 0x1000 recovers. Mid-miss reset: pc=0x1000; the late response is ignored.
